// File: rtl/bp_pkg.sv
// Shared defaults, prediction mode enum and table entry layout for the branch predictor.
package bp_pkg;

  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_ENTRIES = 32;
  localparam int unsigned BP_CTR_W   = 2;
  localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

  typedef enum logic {
    BP_STATIC  = 1'b0,
    BP_BIMODAL = 1'b1
  } bp_mode_e;

  // One BTB entry at the default geometry.
  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load; used per BTB entry and for statistics.
module sat_counter #(
  parameter int unsigned W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_q
);

  // Load has priority; simultaneous inc and dec hold the value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else if (i_load) begin
      o_q <= i_load_val;
    end else if (i_inc && !i_dec && (o_q != '1)) begin
      o_q <= o_q + W'(1);
    end else if (i_dec && !i_inc && (o_q != '0)) begin
      o_q <= o_q - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and EX-stage mispredict detection.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = BP_XLEN,
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned CTR_W   = BP_CTR_W,
  parameter bp_mode_e    MODE    = BP_BIMODAL
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc_f,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_vld,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_is_br,
  input  logic            i_upd_taken,
  input  logic            i_upd_pred_taken,
  input  logic [XLEN-1:0] i_upd_pred_target,
  input  logic            i_flush,
  output logic            o_mispred,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [31:0]     o_num_br,
  output logic [31:0]     o_num_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0]   f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic               f_hit;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic               br_upd;
  logic               alias_upd;
  logic               br_mis;
  logic               alloc;
  logic [ENTRIES-1:0] ctr_inc;
  logic [ENTRIES-1:0] ctr_dec;
  logic [ENTRIES-1:0] ctr_load;

  // Fetch-side lookup against registered table contents.
  always_comb begin
    f_idx         = i_pc_f[IDX_W+1:2];
    f_tag         = i_pc_f[XLEN-1:IDX_W+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    o_pred_taken  = (MODE == BP_BIMODAL) && f_hit && ctr_q[f_idx][CTR_W-1];
    o_pred_target = o_pred_taken ? tgt_q[f_idx] : i_pc_f + XLEN'(4);
  end

  // Resolution-side lookup, mispredict detection and redirect selection.
  always_comb begin
    u_idx     = i_upd_pc[IDX_W+1:2];
    u_tag     = i_upd_pc[XLEN-1:IDX_W+2];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    br_upd    = i_upd_vld && i_upd_is_br;
    alias_upd = i_upd_vld && !i_upd_is_br && i_upd_pred_taken;
    br_mis    = br_upd && ((i_upd_taken != i_upd_pred_taken) ||
                           (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    alloc     = br_upd && !u_hit && i_upd_taken && !i_flush;
    o_mispred = br_mis || alias_upd;
    if (!i_upd_vld) begin
      o_redirect_pc = '0;
    end else if (br_upd && i_upd_taken) begin
      o_redirect_pc = i_upd_target;
    end else begin
      o_redirect_pc = i_upd_pc + XLEN'(4);
    end
  end

  // Per-entry counter controls; a flush suppresses every table write.
  always_comb begin
    ctr_inc  = '0;
    ctr_dec  = '0;
    ctr_load = '0;
    if (br_upd && !i_flush) begin
      if (u_hit) begin
        ctr_inc[u_idx] = i_upd_taken;
        ctr_dec[u_idx] = !i_upd_taken;
      end else begin
        ctr_load[u_idx] = i_upd_taken;
      end
    end
  end

  // Valid/tag/target storage: allocation, target refresh, alias invalidation and bulk flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (i_flush) begin
      valid_q <= '0;
    end else begin
      if (alloc) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= i_upd_target;
      end else if (br_upd && u_hit && i_upd_taken) begin
        tgt_q[u_idx]   <= i_upd_target;
      end
      if (alias_upd && u_hit) begin
        valid_q[u_idx] <= 1'b0;
      end
    end
  end

  // Direction counters, one per entry, reset to weakly not-taken.
  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
    sat_counter #(
      .W       (CTR_W),
      .RST_VAL (CTR_WNT)
    ) u_ctr (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_inc      (ctr_inc[g]),
      .i_dec      (ctr_dec[g]),
      .i_load     (ctr_load[g]),
      .i_load_val (CTR_WT),
      .o_q        (ctr_q[g])
    );
  end

  // Resolved-branch statistic.
  sat_counter #(
    .W       (32),
    .RST_VAL (32'd0)
  ) u_num_br (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (br_upd),
    .i_dec      (1'b0),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .o_q        (o_num_br)
  );

  // Mispredict statistic.
  sat_counter #(
    .W       (32),
    .RST_VAL (32'd0)
  ) u_num_mispred (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (o_mispred),
    .i_dec      (1'b0),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .o_q        (o_num_mispred)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table plus hand sequences for reset and static mode.
module tb_branch_predictor;
  import bp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pc_f;
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic [31:0] i_upd_target;
  logic        i_upd_is_br;
  logic        i_upd_taken;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        i_flush;

  logic        pred_taken, s_pred_taken;
  logic [31:0] pred_target, s_pred_target;
  logic        mispred, s_mispred;
  logic [31:0] redirect_pc, s_redirect_pc;
  logic [31:0] num_br, s_num_br;
  logic [31:0] num_mispred, s_num_mispred;

  branch_predictor dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target),
    .i_upd_is_br(i_upd_is_br), .i_upd_taken(i_upd_taken),
    .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_target(i_upd_pred_target),
    .i_flush(i_flush), .o_mispred(mispred), .o_redirect_pc(redirect_pc),
    .o_num_br(num_br), .o_num_mispred(num_mispred)
  );

  branch_predictor #(.MODE(BP_STATIC)) dut_s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
    .o_pred_taken(s_pred_taken), .o_pred_target(s_pred_target),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target),
    .i_upd_is_br(i_upd_is_br), .i_upd_taken(i_upd_taken),
    .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_target(i_upd_pred_target),
    .i_flush(i_flush), .o_mispred(s_mispred), .o_redirect_pc(s_redirect_pc),
    .o_num_br(s_num_br), .o_num_mispred(s_num_mispred)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc_f;
    logic        vld, is_br, taken, ptk, flush;
    logic [31:0] upc, utgt, ptgt;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_rd;
    int          e_nbr, e_nmis;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [31:0] pc_f, logic vld, logic is_br, logic taken, logic ptk,
                              logic [31:0] upc, logic [31:0] utgt, logic [31:0] ptgt, logic flush,
                              logic e_pt, logic [31:0] e_tgt, logic e_mp, logic [31:0] e_rd,
                              int e_nbr, int e_nmis);
    vec_t v;
    v.pc_f = pc_f; v.vld = vld; v.is_br = is_br; v.taken = taken; v.ptk = ptk;
    v.upc = upc; v.utgt = utgt; v.ptgt = ptgt; v.flush = flush;
    v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_rd = e_rd;
    v.e_nbr = e_nbr; v.e_nmis = e_nmis;
    return v;
  endfunction

  function automatic logic [31:0] actual(int kind);
    case (kind)
      0: return 32'(pred_taken);
      1: return pred_target;
      2: return 32'(mispred);
      3: return redirect_pc;
      4: return num_br;
      5: return num_mispred;
      6: return 32'(s_pred_taken);
      7: return s_num_mispred;
      8: return s_pred_target;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(string nm, int kind, logic [31:0] v);
    exp_t e;
    e.kind = kind; e.exp = v; e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = actual(e.kind);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic set_upd(logic vld, logic is_br, logic taken, logic ptk,
                         logic [31:0] upc, logic [31:0] utgt, logic [31:0] ptgt, logic flush);
    i_upd_vld = vld; i_upd_is_br = is_br; i_upd_taken = taken; i_upd_pred_taken = ptk;
    i_upd_pc = upc; i_upd_target = utgt; i_upd_pred_target = ptgt; i_flush = flush;
  endtask

  task automatic apply(int k, vec_t v);
    string p;
    p = $sformatf("v%0d", k);
    i_pc_f = v.pc_f;
    set_upd(v.vld, v.is_br, v.taken, v.ptk, v.upc, v.utgt, v.ptgt, v.flush);
    expect_val({p, ".pred_taken"}, 0, 32'(v.e_pt));
    expect_val({p, ".pred_target"}, 1, v.e_tgt);
    expect_val({p, ".mispred"}, 2, 32'(v.e_mp));
    if (v.e_mp || !v.vld) expect_val({p, ".redirect"}, 3, v.e_rd);
    expect_val({p, ".static_pred"}, 6, 32'd0);
    if (v.e_nbr >= 0) begin
      expect_val({p, ".num_br"}, 4, 32'(v.e_nbr));
      expect_val({p, ".num_mispred"}, 5, 32'(v.e_nmis));
    end
    #2;
    check_all();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_pc_f  = 32'h100;
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);

    //       pc_f          vld br tk pk upc           utgt      ptgt      fl  ept etgt      emp erd    nbr nmis
    vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h104, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, 1, 1, 1, 0, 32'h100, 32'h40, 32'h104, 0,  0, 32'h104, 1, 32'h40, -1, -1));
    vecs.push_back(mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h40, 32'h40,  0,  1, 32'h40,  1, 32'h104, -1, -1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(32'h100, 1, 1, 0, 0, 32'h100, 32'h40, 32'h104, 0, 0, 32'h104, 0, 32'h0, -1, -1));
    vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h104, 0, 32'h0,   5, 2));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(32'h100, 1, 1, 1, 0, 32'h100, 32'h80, 32'h104, 0, 0, 32'h104, 1, 32'h80, -1, -1));
    vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  1, 32'h80,  0, 32'h0,  -1, -1));
    vecs.push_back(mk(32'h100, 1, 1, 1, 1, 32'h100, 32'h90, 32'h80,  0,  1, 32'h80,  1, 32'h90, -1, -1));
    vecs.push_back(mk(32'h100, 1, 1, 1, 1, 32'h100, 32'h90, 32'h90,  0,  1, 32'h90,  0, 32'h0,   8, 5));
    vecs.push_back(mk(32'h200, 1, 0, 0, 1, 32'h100, 32'h0,  32'h0,   0,  0, 32'h204, 1, 32'h104, -1, -1));
    vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h104, 0, 32'h0,   9, 6));
    vecs.push_back(mk(32'h300, 1, 1, 0, 0, 32'h300, 32'h0,  32'h304, 0,  0, 32'h304, 0, 32'h0,  -1, -1));
    vecs.push_back(mk(32'h300, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h304, 0, 32'h0,  10, 6));
    vecs.push_back(mk(32'h104, 1, 1, 1, 0, 32'h104, 32'h20, 32'h108, 0,  0, 32'h108, 1, 32'h20, -1, -1));
    vecs.push_back(mk(32'h104, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  1, 32'h20,  0, 32'h0,  11, 7));
    vecs.push_back(mk(32'h104, 1, 1, 1, 0, 32'h200, 32'h60, 32'h204, 1,  1, 32'h20,  1, 32'h60, -1, -1));
    vecs.push_back(mk(32'h200, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h204, 0, 32'h0,  12, 8));
    vecs.push_back(mk(32'h104, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h108, 0, 32'h0,  -1, -1));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0,   0, 32'h0,  -1, -1));
    vecs.push_back(mk(32'hFFFF_FFFC, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h0, -1, -1));
    vecs.push_back(mk(32'h100, 0, 1, 1, 1, 32'h100, 32'h40, 32'h104, 0,  0, 32'h104, 0, 32'h0,  12, 9));
    vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   0,  0, 32'h104, 0, 32'h0,  12, 9));

    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge i_clk);
      apply(k, vecs[k]);
    end

    // Allocate 0x100, then reset asynchronously and hold a taken update across a reset edge.
    @(negedge i_clk);
    i_pc_f = 32'h100;
    set_upd(1, 1, 1, 0, 32'h100, 32'h40, 32'h104, 0);
    @(negedge i_clk);
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    expect_val("pre_rst.pred_taken", 0, 32'd1);
    expect_val("pre_rst.pred_target", 1, 32'h40);
    check_all();
    #1 i_rst_n = 1'b0;
    #1;
    expect_val("in_rst.pred_taken", 0, 32'd0);
    expect_val("in_rst.pred_target", 1, 32'h104);
    expect_val("in_rst.num_br", 4, 32'd0);
    expect_val("in_rst.num_mispred", 5, 32'd0);
    check_all();
    set_upd(1, 1, 1, 0, 32'h100, 32'h40, 32'h104, 0);
    @(negedge i_clk);
    #1;
    expect_val("rst_edge.pred_taken", 0, 32'd0);
    expect_val("rst_edge.num_br", 4, 32'd0);
    check_all();
    i_rst_n = 1'b1;
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    expect_val("post_rst.pred_taken", 0, 32'd0);
    expect_val("post_rst.pred_target", 1, 32'h104);
    check_all();

    // First post-reset edges update normally; the static instance never predicts taken.
    for (int r = 0; r < 2; r++) begin
      @(negedge i_clk);
      i_pc_f = 32'h100;
      set_upd(1, 1, 1, 0, 32'h100, 32'h40, 32'h104, 0);
      #2;
      expect_val($sformatf("r%0d.mispred", r), 2, 32'd1);
      expect_val($sformatf("r%0d.redirect", r), 3, 32'h40);
      expect_val($sformatf("r%0d.pred_taken", r), 0, (r == 0) ? 32'd0 : 32'd1);
      expect_val($sformatf("r%0d.pred_target", r), 1, (r == 0) ? 32'h104 : 32'h40);
      expect_val($sformatf("r%0d.static_pred", r), 6, 32'd0);
      expect_val($sformatf("r%0d.static_target", r), 8, 32'h104);
      check_all();
    end
    @(negedge i_clk);
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    expect_val("r_end.static_pred", 6, 32'd0);
    expect_val("r_end.static_num_mispred", 7, 32'd2);
    expect_val("r_end.num_br", 4, 32'd2);
    expect_val("r_end.num_mispred", 5, 32'd2);
    expect_val("r_end.pred_taken", 0, 32'd1);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
